reaction_timer_multi: RTL and testbench

//  Multi-player reaction timer for the DE-board labs. After a start press and a switch-selected delay, the stimulus LED lights.

---
 rtl/reaction_timer_pkg.sv | 36 +++
 rtl/reaction_timer_multi_bcd_tick_counter.sv | 65 ++++++
 rtl/reaction_timer_multi.sv | 211 +++++++++++++++++++++
 tb/tb_reaction_timer_multi.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared types, constants and helpers for the multi-player reaction timer.
package reaction_timer_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, MEASURE, DONE} state_t;

  // Board defaults; instances override CLK_HZ/TICK_HZ and derive their own divider with tick_div().
  localparam int DEFAULT_CLK_HZ  = 50_000_000;
  localparam int DEFAULT_TICK_HZ = 100;
  localparam int TICK_DIV        = DEFAULT_CLK_HZ / DEFAULT_TICK_HZ;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Widest result the BCD compare handles; narrower values are zero-extended.
  localparam int MAX_DIGITS = 8;
  localparam int BCD_CMP_W  = MAX_DIGITS * 4;

  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Magnitude compare of packed BCD, most significant digit decides first.
  function automatic logic bcd_lt(input logic [BCD_CMP_W-1:0] a, input logic [BCD_CMP_W-1:0] b);
    logic lt;
    logic decided;
    lt      = 1'b0;
    decided = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        lt      = (a[i*4 +: 4] < b[i*4 +: 4]);
        decided = 1'b1;
      end
    end
    return lt;
  endfunction

endpackage

// File: rtl/reaction_timer_multi_bcd_tick_counter.sv
// Tick prescaler feeding a cascaded BCD counter that sticks at all 9s.
module bcd_tick_counter
  import reaction_timer_pkg::*;
#(
  parameter int DIV    = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  output logic [DIGITS*4-1:0]   count_bcd,
  output logic                  sat
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]       pre_q, pre_d;
  logic [DIGITS*4-1:0] cnt_q, cnt_d;
  logic                carry;

  assign sat       = (cnt_q == {DIGITS{BCD_MAX}});
  assign count_bcd = cnt_q;

  // Advance the prescaler; on its last cycle ripple a +1 through the BCD digits.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    carry = 1'b0;
    if (clear) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (enable && !sat) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (cnt_q[i*4 +: 4] == BCD_MAX) begin
              cnt_d[i*4 +: 4] = 4'd0;
            end else begin
              cnt_d[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
              carry           = 1'b0;
            end
          end
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: key sync, round FSM, per-player capture and winner pick.
// Optional best-time tracking is built when BEST_TIME_EN is defined.
module reaction_timer_multi
  import reaction_timer_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 100,
  parameter int DIGITS      = 3,
  parameter int NUM_PLAYERS = 2,
  parameter int DELAY_W     = 8
) (
  input  logic                            clk,
  input  logic                            key0,
  input  logic                            key_start,
  input  logic [NUM_PLAYERS-1:0]          key_stop,
  input  logic [DELAY_W-1:0]              delay_sel,
  output logic                            ledr,
  output logic                            busy,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] time_bcd,
  output logic [NUM_PLAYERS-1:0]          done,
  output logic [NUM_PLAYERS-1:0]          false_start,
  output logic [1:0]                      winner,
  output logic                            winner_vld,
  output logic [DIGITS*4-1:0]             best_bcd,
  output logic                            new_best
);

  localparam int TW          = DIGITS * 4;
  localparam int KW          = NUM_PLAYERS + 1;
  localparam int TICK_CYCLES = tick_div(CLK_HZ, TICK_HZ);
  localparam int SEC_W       = $clog2(CLK_HZ);
  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(CLK_HZ - 1);
  localparam logic [TW-1:0]    ALL_NINES = {DIGITS{BCD_MAX}};

  logic [KW-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [KW-1:0] key_ev;
  logic                   start_ev;
  logic [NUM_PLAYERS-1:0] stop_ev;

  state_t                      state_q, state_d;
  logic [DELAY_W-1:0]          delay_q, delay_d;
  logic [SEC_W-1:0]            sec_q, sec_d;
  logic [NUM_PLAYERS*TW-1:0]   time_q, time_d;
  logic [NUM_PLAYERS-1:0]      done_q, done_d;
  logic [NUM_PLAYERS-1:0]      fs_q, fs_d;
  logic [1:0]                  winner_q, winner_d;
  logic                        wv_q, wv_d;
  logic [NUM_PLAYERS-1:0]      capture;
  logic                        cnt_clear;
  logic [TW-1:0]               cnt_bcd;
  logic                        cnt_sat;

  bcd_tick_counter #(.DIV(TICK_CYCLES), .DIGITS(DIGITS)) u_counter (
    .clk       (clk),
    .rst_n     (key0),
    .clear     (cnt_clear),
    .enable    (state_q == MEASURE),
    .count_bcd (cnt_bcd),
    .sat       (cnt_sat)
  );

  // Two-stage synchroniser plus one history stage for falling-edge detect on all keys.
  always_comb begin
    sync1_d = {key_stop, key_start};
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  assign key_ev   = sync3_q & ~sync2_q;
  assign start_ev = key_ev[0];
  assign stop_ev  = key_ev[KW-1:1];

  // Round sequencing, false-start tracking, captures, timeout fill and winner pick.
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    sec_d     = sec_q;
    time_d    = time_q;
    done_d    = done_q;
    fs_d      = fs_q;
    winner_d  = winner_q;
    wv_d      = wv_q;
    capture   = '0;
    cnt_clear = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_ev) begin
          delay_d   = delay_sel;
          sec_d     = '0;
          time_d    = '0;
          done_d    = '0;
          fs_d      = '0;
          winner_d  = '0;
          wv_d      = 1'b0;
          cnt_clear = 1'b1;
          state_d   = (delay_sel == '0) ? MEASURE : WAIT;
        end
      end
      WAIT: begin
        fs_d = fs_q | stop_ev;
        if (&fs_d) begin
          state_d = DONE;
        end else if (sec_q == SEC_LAST) begin
          sec_d   = '0;
          delay_d = delay_q - DELAY_W'(1);
          if (delay_q <= DELAY_W'(1)) state_d = MEASURE;
        end else begin
          sec_d = sec_q + SEC_W'(1);
        end
      end
      MEASURE: begin
        capture = stop_ev & ~fs_q & ~done_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (capture[p]) time_d[p*TW +: TW] = cnt_bcd;
        end
        done_d = done_q | capture;
        if (!wv_q && (|capture)) begin
          wv_d = 1'b1;
          for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (capture[p]) winner_d = 2'(p);
          end
        end
        if ((~fs_q & ~done_d) == '0) begin
          state_d = DONE;
        end else if (cnt_sat) begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (!fs_q[p] && !done_d[p]) time_d[p*TW +: TW] = ALL_NINES;
          end
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Core state registers; key0 clears everything immediately.
  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      sync3_q  <= '1;
      state_q  <= IDLE;
      delay_q  <= '0;
      sec_q    <= '0;
      time_q   <= '0;
      done_q   <= '0;
      fs_q     <= '0;
      winner_q <= '0;
      wv_q     <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      state_q  <= state_d;
      delay_q  <= delay_d;
      sec_q    <= sec_d;
      time_q   <= time_d;
      done_q   <= done_d;
      fs_q     <= fs_d;
      winner_q <= winner_d;
      wv_q     <= wv_d;
    end
  end

  assign ledr        = (state_q == MEASURE);
  assign busy        = (state_q == WAIT) || (state_q == MEASURE);
  assign time_bcd    = time_q;
  assign done        = done_q;
  assign false_start = fs_q;
  assign winner      = winner_q;
  assign winner_vld  = wv_q;

`ifdef BEST_TIME_EN
  logic [TW-1:0] best_q, best_d;
  logic          new_best_q, new_best_d;
  logic [TW-1:0] win_time;

  // On entry to DONE, keep the winner's time if it beats the record.
  always_comb begin
    best_d     = best_q;
    new_best_d = 1'b0;
    win_time   = time_d[TW-1:0];
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (winner_d == 2'(p)) win_time = time_d[p*TW +: TW];
    end
    if ((state_d == DONE) && (state_q != DONE) && wv_d &&
        bcd_lt(BCD_CMP_W'(win_time), BCD_CMP_W'(best_q))) begin
      best_d     = win_time;
      new_best_d = 1'b1;
    end
  end

  // Best-time registers; the record starts at full scale.
  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      best_q     <= ALL_NINES;
      new_best_q <= 1'b0;
    end else begin
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  assign best_bcd = best_q;
  assign new_best = new_best_q;
`else
  assign best_bcd = ALL_NINES;
  assign new_best = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Directed bench for reaction_timer_multi (CLK_HZ=1000, TICK_HZ=100, DIGITS=3, 2 players).
// Best-time expectations follow BEST_TIME_EN.
module tb_reaction_timer_multi;

`ifdef BEST_TIME_EN
  localparam bit BEST_ON = 1'b1;
`else
  localparam bit BEST_ON = 1'b0;
`endif

  logic        clk;
  logic        key0;
  logic        key_start;
  logic [1:0]  key_stop;
  logic [7:0]  delay_sel;
  logic        ledr;
  logic        busy;
  logic [23:0] time_bcd;
  logic [1:0]  done;
  logic [1:0]  false_start;
  logic [1:0]  winner;
  logic        winner_vld;
  logic [11:0] best_bcd;
  logic        new_best;

  int tests_run = 0;
  int fails     = 0;
  int nb_count  = 0;
  int nb_base   = 0;

  reaction_timer_multi #(
    .CLK_HZ(1000), .TICK_HZ(100), .DIGITS(3), .NUM_PLAYERS(2), .DELAY_W(8)
  ) dut (
    .clk         (clk),
    .key0        (key0),
    .key_start   (key_start),
    .key_stop    (key_stop),
    .delay_sel   (delay_sel),
    .ledr        (ledr),
    .busy        (busy),
    .time_bcd    (time_bcd),
    .done        (done),
    .false_start (false_start),
    .winner      (winner),
    .winner_vld  (winner_vld),
    .best_bcd    (best_bcd),
    .new_best    (new_best)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which the best-time pulse is high.
  always @(negedge clk) begin
    if (new_best === 1'b1) nb_count++;
  end

  function automatic logic [11:0] expBest(input logic [11:0] on_val);
    return BEST_ON ? on_val : 12'h999;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic start_n, input logic [1:0] stop_n);
    key_start = start_n;
    key_stop  = stop_n;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitLedr(input logic level, input int bound);
    int n;
    n = 0;
    while (ledr !== level && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ledr_wait", 32'(ledr), 32'(level));
  endtask

  // Zero-delay round, both players stop together after m cycles of MEASURE.
  task automatic bothStopRound(input int m, input logic [11:0] exp_time, input string tag);
    delay_sel = 8'd0;
    applyStimulus(1'b0, 2'b11);
    waitLedr(1'b1, 20);
    applyStimulus(1'b1, 2'b11);
    waitCycles(m);
    applyStimulus(1'b1, 2'b00);
    waitCycles(5);
    checkOutput(tag, 32'(time_bcd), 32'({exp_time, exp_time}));
    applyStimulus(1'b1, 2'b11);
    waitCycles(3);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ledr"},   32'(ledr),        32'd0);
    checkOutput({tag, "_busy"},   32'(busy),        32'd0);
    checkOutput({tag, "_time"},   32'(time_bcd),    32'd0);
    checkOutput({tag, "_done"},   32'(done),        32'd0);
    checkOutput({tag, "_fs"},     32'(false_start), 32'd0);
    checkOutput({tag, "_winner"}, 32'(winner),      32'd0);
    checkOutput({tag, "_wvld"},   32'(winner_vld),  32'd0);
    checkOutput({tag, "_best"},   32'(best_bcd),    32'h999);
    checkOutput({tag, "_newb"},   32'(new_best),    32'd0);
  endtask

  initial begin
    key0 = 1'b0;
    delay_sel = 8'd0;
    applyStimulus(1'b1, 2'b11);
    waitCycles(3);
    checkResetValues("rst");
    key0 = 1'b1;
    waitCycles(3);

    // Round A: 2 s delay, player0 at 47 ticks, player1 at 57 ticks.
    delay_sel = 8'd2;
    applyStimulus(1'b0, 2'b11);
    waitCycles(5);
    applyStimulus(1'b1, 2'b11);
    checkOutput("a_wait_busy", 32'(busy), 32'd1);
    waitCycles(1990);
    checkOutput("a_wait_dark", 32'(ledr), 32'd0);
    waitLedr(1'b1, 30);
    waitCycles(470);
    applyStimulus(1'b1, 2'b10);
    waitCycles(5);
    checkOutput("a_p0_time", 32'(time_bcd[11:0]), 32'h047);
    checkOutput("a_p0_done", 32'(done), 32'b01);
    checkOutput("a_winner", 32'(winner), 32'd0);
    checkOutput("a_wvld", 32'(winner_vld), 32'd1);
    checkOutput("a_still_meas", 32'(ledr), 32'd1);
    applyStimulus(1'b1, 2'b11);
    waitCycles(95);
    applyStimulus(1'b1, 2'b01);
    waitCycles(5);
    checkOutput("a_both_time", 32'(time_bcd), 32'h057047);
    checkOutput("a_both_done", 32'(done), 32'b11);
    checkOutput("a_done_ledr", 32'(ledr), 32'd0);
    checkOutput("a_done_busy", 32'(busy), 32'd0);
    checkOutput("a_winner_hold", 32'(winner), 32'd0);
    checkOutput("a_best", 32'(best_bcd), 32'(expBest(12'h047)));
    applyStimulus(1'b1, 2'b11);
    waitCycles(3);

    // Round B: player1 false-starts, player0 at 12 ticks ends the round.
    delay_sel = 8'd2;
    applyStimulus(1'b0, 2'b11);
    waitCycles(10);
    applyStimulus(1'b1, 2'b11);
    checkOutput("b_clear_time", 32'(time_bcd), 32'd0);
    checkOutput("b_clear_done", 32'(done), 32'd0);
    checkOutput("b_clear_wvld", 32'(winner_vld), 32'd0);
    applyStimulus(1'b1, 2'b01);
    waitCycles(5);
    checkOutput("b_fs", 32'(false_start), 32'b10);
    checkOutput("b_fs_busy", 32'(busy), 32'd1);
    checkOutput("b_fs_ledr", 32'(ledr), 32'd0);
    applyStimulus(1'b1, 2'b11);
    waitLedr(1'b1, 2100);
    waitCycles(120);
    applyStimulus(1'b1, 2'b10);
    waitCycles(5);
    checkOutput("b_time", 32'(time_bcd), 32'h000012);
    checkOutput("b_done", 32'(done), 32'b01);
    checkOutput("b_fs_hold", 32'(false_start), 32'b10);
    checkOutput("b_winner", 32'(winner), 32'd0);
    checkOutput("b_wvld", 32'(winner_vld), 32'd1);
    checkOutput("b_in_done", 32'(ledr), 32'd0);
    checkOutput("b_not_busy", 32'(busy), 32'd0);
    checkOutput("b_best", 32'(best_bcd), 32'(expBest(12'h012)));
    applyStimulus(1'b1, 2'b11);
    waitCycles(3);

    // Round C: both players in the same cycle at 30 ticks.
    bothStopRound(300, 12'h030, "c_time");
    checkOutput("c_done", 32'(done), 32'b11);
    checkOutput("c_winner", 32'(winner), 32'd0);
    checkOutput("c_wvld", 32'(winner_vld), 32'd1);
    checkOutput("c_best", 32'(best_bcd), 32'(expBest(12'h012)));

    // Round D: nobody stops; counter saturates at 999.
    delay_sel = 8'd0;
    applyStimulus(1'b0, 2'b11);
    waitLedr(1'b1, 20);
    applyStimulus(1'b1, 2'b11);
    waitCycles(9985);
    checkOutput("d_pre_sat", 32'(ledr), 32'd1);
    waitLedr(1'b0, 100);
    checkOutput("d_time", 32'(time_bcd), 32'h999999);
    checkOutput("d_done", 32'(done), 32'b00);
    checkOutput("d_wvld", 32'(winner_vld), 32'd0);
    checkOutput("d_winner", 32'(winner), 32'd0);
    checkOutput("d_busy", 32'(busy), 32'd0);
    checkOutput("d_best", 32'(best_bcd), 32'(expBest(12'h012)));

    // Reset asserted mid-MEASURE after player0 has already captured.
    delay_sel = 8'd0;
    applyStimulus(1'b0, 2'b11);
    waitLedr(1'b1, 20);
    applyStimulus(1'b1, 2'b11);
    waitCycles(200);
    applyStimulus(1'b1, 2'b10);
    waitCycles(5);
    checkOutput("r_pre_time", 32'(time_bcd), 32'h000020);
    applyStimulus(1'b1, 2'b11);
    waitCycles(20);
    key0 = 1'b0;
    #1;
    checkResetValues("midrst");
    @(negedge clk);
    key0 = 1'b1;
    waitCycles(3);
    checkOutput("r_idle_ledr", 32'(ledr), 32'd0);
    checkOutput("r_idle_busy", 32'(busy), 32'd0);

    // Best-time rounds: 80, 50, 60 ticks.
    nb_base = nb_count;
    bothStopRound(800, 12'h080, "e_time");
    checkOutput("e_best", 32'(best_bcd), 32'(expBest(12'h080)));
    bothStopRound(500, 12'h050, "f_time");
    checkOutput("f_best", 32'(best_bcd), 32'(expBest(12'h050)));
    bothStopRound(600, 12'h060, "g_time");
    checkOutput("g_best", 32'(best_bcd), 32'(expBest(12'h050)));
    checkOutput("new_best_pulses", 32'(nb_count - nb_base), BEST_ON ? 32'd2 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
